mult_div_unit: RTL and testbench
================================

# mult_div_unit

Execute-stage multiply/divide unit with HI/LO registers for the 5-stage MIPS pipeline. It takes forwarded rs/rt operands from the E-stage forwarding muxes, runs multi-cycle mult/div operations, and holds results in architectural HI/LO. It also exports a busy indication so the hazard unit can stall D-stage mult/div/mfhi/mflo/mthi/mtlo instructions while an operation is in flight. The read port feeds the E-stage result path, alongside the ALU output, for mfhi/mflo.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd/maddu when enabled); must be ≥1.
- DIV_CYCLES, 10, busy cycles for div/divu; must be ≥1.

- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  E-stage instruction is an md op; sampled on the rising edge.
- Mdop  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 madd, 111 maddu.
- A  input  32  rs operand, post-forwarding (MFRSE output).
- B  input  32  rt operand, post-forwarding (MFRTE output).
- Hilo_sel  input  1  read select: 0 selects LO, 1 selects HI.
- Busy  output  1  operation in flight, registered.
- Md_hazard  output  1  Start | Busy, combinational; to the hazard unit.
- Out  output  32  combinational read of the HI or LO register, per Hilo_sel.

## Operation
- State: HI[31:0], LO[31:0], pend_hi/pend_lo (result shadows), cnt[3:0]. Busy = (cnt != 0), registered.
- Idle (cnt==0) and Start:
  - mult/multu: {pend_hi,pend_lo} = A*B, signed or unsigned; cnt ← MULT_CYCLES.
  - div/divu: pend_lo = A/B, pend_hi = A%B, with cnt ← DIV_CYCLES. Signed division truncates toward zero; the remainder takes the sign of A.
  - mthi/mtlo: HI←A or LO←A on this edge; cnt unchanged (0). Busy is never asserted.
  - madd/maddu: only when compiled in (see Configuration); otherwise treated as no-op, no state change.
- Running (cnt>0): cnt decrements every edge. On the edge where cnt goes 1→0, HI←pend_hi and LO←pend_lo.
- Start while Busy: ignored entirely; HI, LO, the pending shadows and cnt are unchanged. The hazard unit guarantees this cannot happen; an assertion flags it in simulation.
- Divide by zero (B==0, div or divu): the full DIV_CYCLES busy period still runs, and HI/LO are left unchanged at commit.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- Operands are consumed at the Start edge. Later changes on A/B have no effect.
- Out reflects committed HI/LO only, never pending results.

## Timing
- Reset low (async): HI=0, LO=0, pend_hi=0, pend_lo=0, cnt=0, Busy=0. Out=0. Md_hazard=Start.
- Reset asserted mid-operation aborts it. The pending result is discarded and Busy drops immediately.
- mult started at edge k: Busy=1 after edges k .. k+MULT_CYCLES-1. At edge k+MULT_CYCLES, Busy=0 and the new HI/LO are visible on Out in the same cycle.
- div uses the same rule with DIV_CYCLES.
- mthi/mtlo at edge k: the new value is visible on Out after edge k, with zero busy cycles.
- Md_hazard is high in the Start cycle itself, so a dependent md instruction in D stalls from that cycle onward.
- An mfhi/mflo issued the cycle after Busy falls reads the committed value. There is no bypass from pending results.

## Configuration
- MDU_MADD_EN defined:
  - Mdop 110/111 perform {HI,LO} + A*B (signed or unsigned, 64-bit, wrap modulo 2^64) into the pending shadows.
  - The addend is the current HI/LO sampled at the Start edge.
  - Busy for MULT_CYCLES; commit rules are the same as mult.
- MDU_MADD_EN undefined: Mdop 110/111 are no-ops (no state change, Busy stays 0), and the multiply-accumulate logic is not instantiated.

## Test plan
- Reset low mid-div (cnt=4) → Busy=0 and HI=LO=0 immediately. After release, mflo Out=0.
- mult A=0xFFFFFFFF, B=2 → Busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- div A=-7 (0xFFFFFFF9), B=2 → after 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=0 → 10 busy cycles, HI/LO unchanged.
- mtlo A=0x12345678, then Hilo_sel=0 on the next cycle → Out=0x12345678, Busy never 1.
- Start mult, then Start div two cycles later while Busy → div ignored; the mult result commits at cycle 5, and Md_hazard=1 throughout.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, maddu A=1, B=1 → HI=1, LO=0 after 5 cycles. Without MDU_MADD_EN: the same stimulus → HI=0, LO=0xFFFFFFFF, Busy=0.

Source files
------------

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Brief    : E-stage multi-cycle multiply/divide unit with architectural HI/LO.
//            Optional multiply-accumulate (madd/maddu) enabled by MDU_MADD_EN.
// Revision : 1.0  initial release
// ============================================================================
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hilo_sel,
  output logic        busy,
  output logic        md_hazard,
  output logic [31:0] out
);

  localparam int unsigned CNT_W = 4;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MADDU = 3'b111;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  generate
    if (MULT_CYCLES < 1 || MULT_CYCLES > 15) begin : g_bad_mult_cycles
      $error("MULT_CYCLES must be in 1..15");
    end
    if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div_cycles
      $error("DIV_CYCLES must be in 1..15");
    end
  endgenerate

  logic [31:0]      hi, lo, pend_hi, pend_lo;
  logic [31:0]      hi_n, lo_n, pend_hi_n, pend_lo_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  // Multiplier: even opcodes of each pair (mult, madd) are signed.
  logic        mul_signed;
  logic [63:0] a_ext, b_ext, product;

  assign mul_signed = ~mdop[0];
  assign a_ext      = {{32{mul_signed & a[31]}}, a};
  assign b_ext      = {{32{mul_signed & b[31]}}, b};
  assign product    = a_ext * b_ext;

  // Signed divide on magnitudes so that 0x80000000 / -1 wraps to 0x80000000
  // without relying on the host's signed-overflow behaviour.
  logic        div_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, uq, ur, quot, rem;

  assign div_signed = ~mdop[0];
  assign a_neg      = div_signed & a[31];
  assign b_neg      = div_signed & b[31];
  assign a_mag      = a_neg ? (32'd0 - a) : a;
  assign b_mag      = b_neg ? (32'd0 - b) : b;
  assign uq         = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
  assign ur         = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
  assign quot       = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
  assign rem        = a_neg ? (32'd0 - ur) : ur;

  logic [63:0] acc;
`ifdef MDU_MADD_EN
  assign acc = {hi, lo} + product;
`else
  assign acc = 64'd0;
`endif

  // Next-state logic
  always_comb begin
    hi_n      = hi;
    lo_n      = lo;
    pend_hi_n = pend_hi;
    pend_lo_n = pend_lo;
    cnt_n     = cnt;
    if (cnt != '0) begin
      cnt_n = cnt - 1'b1;
      if (cnt == CNT_W'(1)) begin
        hi_n = pend_hi;
        lo_n = pend_lo;
      end
    end else if (start) begin
      case (mdop)
        OP_MULT, OP_MULTU: begin
          {pend_hi_n, pend_lo_n} = product;
          cnt_n                  = MULT_LOAD;
        end
        OP_DIV, OP_DIVU: begin
          // Divide by zero commits the current HI/LO back, i.e. no change.
          if (b == 32'd0) begin
            pend_hi_n = hi;
            pend_lo_n = lo;
          end else begin
            pend_hi_n = rem;
            pend_lo_n = quot;
          end
          cnt_n = DIV_LOAD;
        end
        OP_MTHI: hi_n = a;
        OP_MTLO: lo_n = a;
        OP_MADD, OP_MADDU: begin
`ifdef MDU_MADD_EN
          {pend_hi_n, pend_lo_n} = acc;
          cnt_n                  = MULT_LOAD;
`endif
        end
        default: ;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      cnt     <= '0;
      busy    <= 1'b0;
    end else begin
      hi      <= hi_n;
      lo      <= lo_n;
      pend_hi <= pend_hi_n;
      pend_lo <= pend_lo_n;
      cnt     <= cnt_n;
      busy    <= (cnt_n != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(start && busy))
        else $warning("mult_div_unit: start while busy is ignored");
    end
  end

  // Outputs
  assign md_hazard = start | busy;
  assign out       = hilo_sel ? hi : lo;

  logic unused_acc;
  assign unused_acc = ^acc;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Brief    : Directed + random bench for mult_div_unit against an arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        rst_n, start, hilo_sel, busy, md_hazard;
  logic [2:0]  mdop;
  logic [31:0] a, b, out;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mdop(mdop), .a(a), .b(b),
    .hilo_sel(hilo_sel), .busy(busy), .md_hazard(md_hazard), .out(out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: MIPS semantics in plain 64-bit arithmetic.
  task automatic model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                       inout logic [31:0] h, inout logic [31:0] l, output int cyc);
    longint          sx, sy, sq, sr;
    longint unsigned ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    cyc = 0;
    case (op)
      3'd0: begin p = sx * sy; {h, l} = p; cyc = MC; end
      3'd1: begin p = ux * uy; {h, l} = p; cyc = MC; end
      3'd2: begin
        if (y != 0) begin sq = sx / sy; sr = sx % sy; l = sq[31:0]; h = sr[31:0]; end
        cyc = DC;
      end
      3'd3: begin
        if (y != 0) begin p = ux / uy; l = p[31:0]; p = ux % uy; h = p[31:0]; end
        cyc = DC;
      end
      3'd4: h = x;
      3'd5: l = x;
      default: begin
`ifdef MDU_MADD_EN
        p = (op == 3'd6) ? longint'(sx * sy) : (ux * uy);
        p = {h, l} + p;
        {h, l} = p;
        cyc = MC;
`endif
      end
    endcase
  endtask

  task automatic check_out(input string tag);
    hilo_sel = 1'b0; #1 chk({tag, "/lo"}, out, m_lo);
    hilo_sel = 1'b1; #1 chk({tag, "/hi"}, out, m_hi);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] x,
                        input logic [31:0] y);
    logic [31:0] nh, nl;
    int cyc;
    nh = m_hi; nl = m_lo;
    model(op, x, y, nh, nl, cyc);
    @(negedge clk);
    start = 1'b1; mdop = op; a = x; b = y;
    #1 chk({tag, "/hazard_start"}, {31'd0, md_hazard}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    for (int i = 0; i < cyc; i++) begin
      chk({tag, "/busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "/hazard_busy"}, {31'd0, md_hazard}, 32'd1);
      hilo_sel = 1'($urandom_range(0, 1));
      #1 chk({tag, "/no_bypass"}, out, hilo_sel ? m_hi : m_lo);
      @(posedge clk); #1;
    end
    m_hi = nh; m_lo = nl;
    chk({tag, "/idle"}, {31'd0, busy}, 32'd0);
    check_out(tag);
  endtask

  initial begin
    logic [31:0] nh, nl, x, y;
    logic [2:0]  op;
    int          cyc;

    rst_n = 1'b0; start = 1'b0; mdop = 3'd0; a = 32'd0; b = 32'd0; hilo_sel = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    #1 chk("rst/busy", {31'd0, busy}, 32'd0);
    chk("rst/hazard", {31'd0, md_hazard}, 32'd0);
    check_out("rst");
    start = 1'b1;
    #1 chk("rst/hazard_eq_start", {31'd0, md_hazard}, 32'd1);
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    run_op("mult", 3'd0, 32'hFFFF_FFFF, 32'd2);
    hilo_sel = 1'b1; #1 chk("mult/hi_const", out, 32'hFFFF_FFFF);
    hilo_sel = 1'b0; #1 chk("mult/lo_const", out, 32'hFFFF_FFFE);
    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2);
    hilo_sel = 1'b1; #1 chk("multu/hi_const", out, 32'h0000_0001);
    run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2);
    hilo_sel = 1'b0; #1 chk("div/lo_const", out, 32'hFFFF_FFFD);
    hilo_sel = 1'b1; #1 chk("div/hi_const", out, 32'hFFFF_FFFF);
    run_op("divu_zero", 3'd3, 32'd7, 32'd0);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    hilo_sel = 1'b0; #1 chk("div_ovf/lo_const", out, 32'h8000_0000);
    run_op("mtlo", 3'd5, 32'h1234_5678, 32'd0);
    run_op("mthi", 3'd4, 32'hCAFE_F00D, 32'd0);

    // Reset in the middle of a divide, with cnt at 4
    @(negedge clk);
    start = 1'b1; mdop = 3'd2; a = 32'd100; b = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("rst_mid/busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1 chk("rst_mid/busy", {31'd0, busy}, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    check_out("rst_mid");
    @(negedge clk) rst_n = 1'b1;
    repeat (DC) @(posedge clk);
    #1 check_out("rst_mid_after");

    // Start while busy is dropped
    x = 32'h0001_2345; y = 32'hFFFF_FF00;
    nh = m_hi; nl = m_lo;
    model(3'd0, x, y, nh, nl, cyc);
    @(negedge clk);
    start = 1'b1; mdop = 3'd0; a = x; b = y;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 1; i < MC; i++) begin
      if (i == 2) begin
        @(negedge clk);
        start = 1'b1; mdop = 3'd2; a = $urandom; b = $urandom | 32'd1;
      end
      @(posedge clk); #1 start = 1'b0;
      chk("overlap/busy", {31'd0, busy}, 32'd1);
      chk("overlap/hazard", {31'd0, md_hazard}, 32'd1);
    end
    @(posedge clk); #1;
    chk("overlap/done", {31'd0, busy}, 32'd0);
    m_hi = nh; m_lo = nl;
    check_out("overlap");
    @(posedge clk); #1;
    chk("overlap/div_dropped", {31'd0, busy}, 32'd0);
    check_out("overlap_later");

    // Multiply-accumulate (or no-op when not compiled in)
    run_op("mthi0", 3'd4, 32'd0, 32'd0);
    run_op("mtlo1s", 3'd5, 32'hFFFF_FFFF, 32'd0);
    run_op("maddu", 3'd7, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    hilo_sel = 1'b1; #1 chk("maddu/hi_const", out, 32'h0000_0001);
    hilo_sel = 1'b0; #1 chk("maddu/lo_const", out, 32'h0000_0000);
`else
    hilo_sel = 1'b1; #1 chk("maddu/hi_const", out, 32'h0000_0000);
    hilo_sel = 1'b0; #1 chk("maddu/lo_const", out, 32'hFFFF_FFFF);
`endif
    run_op("madd", 3'd6, 32'hFFFF_FFF0, 32'd3);

    for (int k = 0; k < 30; k++) begin
      op = 3'($urandom_range(0, 7));
      x  = $urandom;
      y  = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op("rand", op, x, y);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
